// File: rtl/car_pkg.sv
// Shared constants, FSM state and slot record for the car scheduler.
package car_pkg;

   localparam int NUM_CARS = 20;
   localparam int SCREEN_V = 480;
   localparam int SPRITE_SIZE = 32;
   localparam logic [4:0] GLOBAL_ADDR = 5'd31;
   localparam logic [10:0] OFF_SCREEN = 11'h7FF;

   typedef enum logic [1:0] {
      IDLE,
      UPDATE,
      COMMIT
   } state_t;

   typedef struct packed {
      logic        en;
      logic [10:0] x;
      logic [10:0] y;
      logic [3:0]  speed;
      logic [3:0]  ctrl;
   } slot_t;

endpackage

// File: rtl/car_overlap.sv
// Combinational 32x32 box overlap test between two sprite origins.
module car_overlap
   import car_pkg::*;
(
   input  logic [10:0] ax,
   input  logic [10:0] ay,
   input  logic [10:0] bx,
   input  logic [10:0] by,
   output logic        overlap
);

   logic [11:0] dx;
   logic [11:0] dy;
   logic [11:0] adx;
   logic [11:0] ady;

   always_comb begin
      dx = {1'b0, ax} - {1'b0, bx};
      dy = {1'b0, ay} - {1'b0, by};
      adx = dx[11] ? (12'd0 - dx) : dx;
      ady = dy[11] ? (12'd0 - dy) : dy;
      overlap = (adx < 12'(SPRITE_SIZE))
         && (ady < 12'(SPRITE_SIZE));
   end

endmodule

// File: rtl/car_sched.sv
// Per-frame car sprite scheduler with shadowed outputs.
// Optional player collision detection: define CAR_COLLIDE_EN.
module car_sched #(
   parameter int NUM_CARS = car_pkg::NUM_CARS,
   parameter int SCREEN_V = car_pkg::SCREEN_V
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   frame_tick,
   input  logic                   cs,
   input  logic                   write,
   input  logic [4:0]             addr,
   input  logic [31:0]            wr_data,
   output logic [31:0]            rd_data,
   input  logic [10:0]            player_x,
   input  logic [10:0]            player_y,
   output logic [NUM_CARS*11-1:0] car_x,
   output logic [NUM_CARS*11-1:0] car_y,
   output logic [NUM_CARS*4-1:0]  car_ctrl,
   output logic                   hit
);

   import car_pkg::*;

   state_t      state;
   state_t      state_nx;
   logic [4:0]  idx;
   slot_t       slots [NUM_CARS];
   logic        run;
   logic        overrun;
   logic [7:0]  wrap_cnt;
   logic        busy;
   logic        last;
   logic        slot_wr;
   logic        glb_wr;
   logic        clear;
   logic        clash;
   logic        step;
   logic        cur_en;
   logic [10:0] cur_y;
   logic [3:0]  cur_spd;
   logic [11:0] y_sum;
   logic        wrapped;
   logic [10:0] y_new;
   slot_t       wr_slot;
   logic        unused_wr;

   assign busy = (state != IDLE);
   assign last = (idx == 5'(NUM_CARS - 1));
   assign slot_wr = cs && write && (addr < 5'(NUM_CARS));
   assign glb_wr = cs && write && (addr == GLOBAL_ADDR);
   assign clear = glb_wr && wr_data[1];
   assign unused_wr = ^wr_data[31:20];

   assign cur_en = slots[idx].en;
   assign cur_y = slots[idx].y;
   assign cur_spd = slots[idx].speed;

   // A bus write to the slot being stepped wins over the arithmetic.
   assign clash = slot_wr && (addr == idx);
   assign step = (state == UPDATE) && cur_en && !clash;

   assign y_sum = {1'b0, cur_y} + {8'd0, cur_spd};
   assign wrapped = (y_sum >= 12'(SCREEN_V));
   assign y_new = wrapped ? 11'd0 : y_sum[10:0];

   always_comb begin
      wr_slot = '0;
      wr_slot.x = wr_data[10:0];
      wr_slot.speed = wr_data[14:11];
      wr_slot.ctrl = wr_data[18:15];
      wr_slot.en = wr_data[19];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (frame_tick && run) state_nx = UPDATE;
         UPDATE:  if (last) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx <= '0;
      end else if (state == UPDATE && !last) begin
         idx <= idx + 5'd1;
      end else begin
         idx <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CARS; i++) begin
            slots[i] <= '0;
         end
      end else begin
         if (step) begin
            slots[idx].y <= y_new;
         end
         if (slot_wr) begin
            slots[addr] <= wr_slot;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run <= 1'b0;
         overrun <= 1'b0;
         wrap_cnt <= '0;
      end else begin
         if (glb_wr) begin
            run <= wr_data[0];
         end
         if (clear) begin
            overrun <= 1'b0;
            wrap_cnt <= '0;
         end else begin
            if (frame_tick && busy) begin
               overrun <= 1'b1;
            end
            if (step && wrapped && wrap_cnt != 8'hFF) begin
               wrap_cnt <= wrap_cnt + 8'd1;
            end
         end
      end
   end

   // Shadows change only in COMMIT so a frame never shows a half pass.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         car_x <= '1;
         car_y <= '1;
         car_ctrl <= '0;
      end else if (state == COMMIT) begin
         for (int i = 0; i < NUM_CARS; i++) begin
            if (slots[i].en) begin
               car_x[i*11 +: 11] <= slots[i].x;
               car_y[i*11 +: 11] <= slots[i].y;
               car_ctrl[i*4 +: 4] <= slots[i].ctrl;
            end else begin
               car_x[i*11 +: 11] <= OFF_SCREEN;
               car_y[i*11 +: 11] <= OFF_SCREEN;
               car_ctrl[i*4 +: 4] <= 4'd0;
            end
         end
      end
   end

`ifdef CAR_COLLIDE_EN
   logic ovl;
   logic hit_q;

   car_overlap u_overlap (
      .ax      (slots[idx].x),
      .ay      (y_new),
      .bx      (player_x),
      .by      (player_y),
      .overlap (ovl)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_q <= 1'b0;
      end else if (clear) begin
         hit_q <= 1'b0;
      end else if (step && ovl) begin
         hit_q <= 1'b1;
      end
   end

   assign hit = hit_q;
`else
   logic unused_player;
   assign unused_player = ^{player_x, player_y};
   assign hit = 1'b0;
`endif

   assign rd_data = {overrun, hit, busy, run, 20'd0, wrap_cnt};

endmodule

// File: doc/car_sched.md
CAR_SCHED -- requirements
Module: car_sched

Interface
REQ-001 SHALL have parameter NUM_CARS, default 20: number of car slots.
REQ-002 SHALL have parameter SCREEN_V, default 480: vertical wrap limit in pixels.
REQ-003 SHALL have port clk, input, 1: the only clock.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port frame_tick, input, 1: one-cycle pulse at start of vertical blank.
REQ-006 SHALL have ports cs/write, input, 1 each: bus select and write strobe.
REQ-007 SHALL have port addr, input, 5: slot index 0..NUM_CARS-1; 31 = global register.
REQ-008 SHALL have port wr_data, input, 32: bus write data.
REQ-009 SHALL have port rd_data, output, 32: status word {overrun[31], hit[30], busy[29], run[28], 20'b0, wrap_cnt[7:0]}.
REQ-010 SHALL have ports player_x/player_y, input, 11 each: player sprite origin.
REQ-011 SHALL have ports car_x/car_y, output, NUM_CARS x 11 packed: sprite origins.
REQ-012 SHALL have port car_ctrl, output, NUM_CARS x 4 packed: {color_sel, id_sel} per slot.
REQ-013 SHALL have port hit, output, 1: sticky collision flag.

Function
REQ-014 Slot write (cs&write, addr<NUM_CARS) SHALL load x=wr_data[10:0], speed=wr_data[14:11], ctrl=wr_data[18:15], en=wr_data[19], and clear y to 0.
REQ-015 Global write (addr=31) SHALL set run=wr_data[0]; wr_data[1]=1 SHALL clear overrun, hit and wrap_cnt.
REQ-016 FSM SHALL have states IDLE, UPDATE, COMMIT.
REQ-017 IDLE->UPDATE on frame_tick with run=1; otherwise stay in IDLE.
REQ-018 UPDATE SHALL process slot i in the i-th cycle after entry, with i running 0..NUM_CARS-1, and SHALL go to COMMIT after the last slot.
REQ-019 COMMIT SHALL last 1 cycle, then go to IDLE; busy=1 in UPDATE and COMMIT.
REQ-020 Per enabled slot: y_new=y+speed computed at 12 bits; if y_new>=SCREEN_V then y=0 and wrap_cnt increments, saturating at 255.
REQ-021 A disabled slot SHALL keep its working y unchanged.
REQ-022 Outputs SHALL be shadow registers copied from working state only in COMMIT: no mid-frame tearing; output latency from frame_tick is NUM_CARS+2 cycles.
REQ-023 In COMMIT, a disabled slot SHALL drive car_x=car_y=11'h7FF (never on screen) and car_ctrl=0.
REQ-024 frame_tick in UPDATE or COMMIT SHALL be ignored and SHALL set sticky overrun.
REQ-025 A bus slot write in the same cycle that UPDATE processes that slot SHALL take priority; the arithmetic result for that slot SHALL be discarded.
REQ-026 rd_data SHALL be combinational from current registers, independent of addr.

Reset
REQ-027 reset_n low SHALL force IDLE, run=0, all slots en=0, x=y=speed=ctrl=0, wrap_cnt=0, overrun=0, hit=0.
REQ-028 While reset_n is low, outputs SHALL be car_x=car_y=all 11'h7FF, car_ctrl=0, rd_data=0.
REQ-029 Reset asserted mid-UPDATE SHALL abort the pass with no partial commit.

Configuration
REQ-030 With CAR_COLLIDE_EN defined: in UPDATE, an enabled slot whose new 32x32 box overlaps the player 32x32 box (|dx|<32 and |dy|<32) SHALL set hit.
REQ-031 Without CAR_COLLIDE_EN: hit and rd_data[30] SHALL be constant 0 and player_x/player_y SHALL be unused.

Structure
REQ-032 A shared package car_pkg SHALL hold NUM_CARS, SCREEN_V, SPRITE_SIZE=32, the FSM state enum, the slot record typedef {en, x, y, speed, ctrl} and the address constant GLOBAL_ADDR=31.
REQ-033 The overlap test SHALL be a sub-module car_overlap (combinational box compare), instantiated once and time-shared across slots.

Verification
REQ-034 Write slot 3 {x=100, speed=4, ctrl=4'b0110, en=1}, run=1, 2 frame_ticks -> after the second commit, car_y[3]=8, car_x[3]=100, car_ctrl[3]=6.
REQ-035 Slot 0 speed=15, y preloaded by 31 frames to 465 -> next frame car_y[0]=0, wrap_cnt=1.
REQ-036 Second frame_tick 5 cycles after the first -> overrun=1; outputs update exactly once, at cycle NUM_CARS+2.
REQ-037 Slot 5 disabled -> car_x[5]=car_y[5]=11'h7FF after commit; outputs stay unchanged during UPDATE.
REQ-038 CAR_COLLIDE_EN, player at (100,8), slot 3 as in REQ-034 -> hit=1 after the second frame; write wr_data[1]=1 to addr 31 -> hit=0.
REQ-039 reset_n low at cycle 10 of UPDATE -> FSM in IDLE, all outputs at reset values, no commit occurs.
